// File: rtl/core_pkg.sv
// Shared core constants and types used by the register-file dump engine,
// the register file and the decode stage.
package core_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready beat stream carrying one register index and value per beat.
interface regfile_dump_if #(
    parameter int XLEN = core_pkg::XLEN
);

    logic                  out_valid;
    logic                  out_ready;
    core_pkg::reg_idx_t    out_idx;
    logic [XLEN-1:0]       out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_idx,
        output out_data,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_idx,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks x0..NREGS-1 through an async register-file read
// port and streams each value out, holding a freeze request while active.
module regfile_dump #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int NREGS = core_pkg::NREGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  freeze_req,
    output core_pkg::reg_idx_t    rf_addr,
    input  logic [XLEN-1:0]       rf_data,
    regfile_dump_if.master        out_if
);

    localparam core_pkg::reg_idx_t LAST_IDX = core_pkg::reg_idx_t'(NREGS - 1);
    localparam core_pkg::reg_idx_t ONE_IDX  = core_pkg::reg_idx_t'(1);

    core_pkg::dump_state_t state_q, state_d;
    core_pkg::reg_idx_t    idx_q, idx_d;
    core_pkg::reg_idx_t    out_idx_q, out_idx_d;
    logic [XLEN-1:0]       out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  handshake;

    assign handshake = out_valid_q & out_if.out_ready;

    // On a handshake the read address already points at the next register, so
    // its value is captured at the same edge and beats run back to back.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rf_addr     = '0;

        case (state_q)
            core_pkg::IDLE: begin
                if (start) begin
                    state_d = core_pkg::FETCH;
                    idx_d   = '0;
                end
            end
            core_pkg::FETCH: begin
                rf_addr     = idx_q;
                out_data_d  = rf_data;
                out_idx_d   = idx_q;
                out_valid_d = 1'b1;
                state_d     = core_pkg::SEND;
            end
            core_pkg::SEND: begin
                rf_addr = idx_q;
                if (handshake) begin
                    if (idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        state_d     = core_pkg::DONE;
                    end else begin
                        rf_addr    = idx_q + ONE_IDX;
                        out_data_d = rf_data;
                        out_idx_d  = idx_q + ONE_IDX;
                        idx_d      = idx_q + ONE_IDX;
                    end
                end
            end
            core_pkg::DONE: begin
                state_d = core_pkg::IDLE;
            end
            default: begin
                state_d = core_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= core_pkg::IDLE;
            idx_q       <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy              = (state_q != core_pkg::IDLE);
    assign done              = (state_q == core_pkg::DONE);
    assign freeze_req        = busy;
    assign out_if.out_valid  = out_valid_q;
    assign out_if.out_idx    = out_idx_q;
    assign out_if.out_data   = out_data_q;
    assign out_if.out_last   = out_valid_q & (out_idx_q == LAST_IDX);

endmodule
